// File: rtl/labfinalsoc_hex_display_ctrl.sv
// Avalon-MM seven-segment display controller: per-digit nibble storage, atomic set/clear,
// blank and blink masks, and a programmable blink timer driving registered active-low segments.
module labfinalsoc_hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned BLINK_DIV_RESET = 25000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2:0]                address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic [4*NUM_DIGITS-1:0]   out_port,
    output logic [7*NUM_DIGITS-1:0]   hex_seg
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned SW = 7 * NUM_DIGITS;

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrBlank    = 3'd1;
    localparam logic [2:0] AddrBlink    = 3'd2;
    localparam logic [2:0] AddrBlinkDiv = 3'd3;
    localparam logic [2:0] AddrDataSet  = 3'd4;
    localparam logic [2:0] AddrDataClr  = 3'd5;
    localparam logic [2:0] AddrStatus   = 3'd6;

    logic [DW-1:0]         data_q, data_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [NUM_DIGITS-1:0] blink_q, blink_d;
    logic [31:0]           div_q, div_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic                  event_q, event_d;
    logic [SW-1:0]         seg_q, seg_d;

    logic wr;
    logic div_wr;
    logic toggle;
    logic vis;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign wr     = chipselect & ~write_n;
    assign div_wr = wr && (address == AddrBlinkDiv);

    // Register file updates, including the atomic set/clear aliases of DATA.
    always_comb begin
        data_d  = data_q;
        blank_d = blank_q;
        blink_d = blink_q;
        div_d   = div_q;
        if (wr) begin
            case (address)
                AddrData:     data_d  = writedata[DW-1:0];
                AddrBlank:    blank_d = writedata[NUM_DIGITS-1:0];
                AddrBlink:    blink_d = writedata[NUM_DIGITS-1:0];
                AddrBlinkDiv: div_d   = writedata;
                AddrDataSet:  data_d  = data_q | writedata[DW-1:0];
                AddrDataClr:  data_d  = data_q & ~writedata[DW-1:0];
                default:      ;
            endcase
        end
    end

    // Blink timer; a divider write restarts the period with the digit visible.
    always_comb begin
        cnt_d   = cnt_q + 32'd1;
        phase_d = phase_q;
        toggle  = 1'b0;
        if (div_wr || (div_q == 32'd0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == div_q - 32'd1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            toggle  = 1'b1;
        end
    end

    // Hardware set takes priority over a simultaneous software clear.
    always_comb begin
        event_d = event_q;
        if (wr && (address == AddrStatus) && writedata[1]) begin
            event_d = 1'b0;
        end
        if (toggle) begin
            event_d = 1'b1;
        end
    end

    always_comb begin
        seg_d = '1;
        vis   = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            vis = ~blank_q[i] & (~blink_q[i] | phase_q);
            seg_d[7*i +: 7] = vis ? hex_decode(data_q[4*i +: 4]) : 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            blank_q <= '0;
            blink_q <= '0;
            div_q   <= 32'(BLINK_DIV_RESET);
            cnt_q   <= '0;
            phase_q <= 1'b1;
            event_q <= 1'b0;
            seg_q   <= {NUM_DIGITS{7'h40}};
        end else begin
            data_q  <= data_d;
            blank_q <= blank_d;
            blink_q <= blink_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            event_q <= event_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            AddrData:     readdata[DW-1:0]         = data_q;
            AddrBlank:    readdata[NUM_DIGITS-1:0] = blank_q;
            AddrBlink:    readdata[NUM_DIGITS-1:0] = blink_q;
            AddrBlinkDiv: readdata                 = div_q;
            AddrStatus:   readdata[1:0]            = {event_q, phase_q};
            default:      readdata                 = '0;
        endcase
    end

    assign out_port = data_q;
    assign hex_seg  = seg_q;

endmodule

// File: tb/tb_labfinalsoc_hex_display_ctrl.sv
// Self-checking bench for labfinalsoc_hex_display_ctrl: elapsed-time blink model plus directed
// literal checks for the reset, data, set/clear, blink, blank and mid-blink reset scenarios.
module tb_labfinalsoc_hex_display_ctrl;

    localparam int unsigned DIV_RST = 25000000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] out_port;
    logic [27:0] hex_seg;

    int n_pass  = 0;
    int n_total = 0;

    labfinalsoc_hex_display_ctrl #(
        .NUM_DIGITS      (4),
        .BLINK_DIV_RESET (DIV_RST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .hex_seg    (hex_seg)
    );

    always #5 clk = ~clk;

    // Model: blink phase derived from edges elapsed since the timer last restarted.
    logic [6:0]       glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0]      m_data;
    logic [3:0]       m_blank;
    logic [3:0]       m_blink;
    logic [31:0]      m_div;
    longint unsigned  m_t;
    logic             m_event;
    logic [27:0]      m_seg;
    logic             bus_wr;

    assign bus_wr = chipselect & ~write_n;

    function automatic logic model_phase();
        if (m_div == 32'd0) return 1'b1;
        return ((m_t / longint'(m_div)) % 2) == 0;
    endfunction

    function automatic logic [27:0] model_seg(input logic [15:0] d, input logic [3:0] bl,
                                              input logic [3:0] bk, input logic ph);
        logic [27:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[7*i +: 7] = (!bl[i] && (!bk[i] || ph)) ? glyph[d[4*i +: 4]] : 7'h7F;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {16'h0, m_data};
            3'd1: return {28'h0, m_blank};
            3'd2: return {28'h0, m_blink};
            3'd3: return m_div;
            3'd6: return {30'h0, m_event, model_phase()};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data  <= '0;
            m_blank <= '0;
            m_blink <= '0;
            m_div   <= DIV_RST;
            m_t     <= 0;
            m_event <= 1'b0;
            m_seg   <= {4{7'h40}};
        end else begin
            m_seg <= model_seg(m_data, m_blank, m_blink, model_phase());
            if (bus_wr) begin
                case (address)
                    3'd0: m_data  <= writedata[15:0];
                    3'd1: m_blank <= writedata[3:0];
                    3'd2: m_blink <= writedata[3:0];
                    3'd4: m_data  <= m_data | writedata[15:0];
                    3'd5: m_data  <= m_data & ~writedata[15:0];
                    default: ;
                endcase
            end
            if (bus_wr && address == 3'd3) begin
                m_div <= writedata;
                m_t   <= 0;
            end else if (m_div == 32'd0) begin
                m_t <= 0;
            end else begin
                m_t <= m_t + 1;
            end
            if (m_div != 0 && !(bus_wr && address == 3'd3) && ((m_t + 1) % m_div) == 0)
                m_event <= 1'b1;
            else if (bus_wr && address == 3'd6 && writedata[1])
                m_event <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Every cycle: compare all outputs against the model, then advance to posedge+1.
    task automatic tick();
        @(negedge clk);
        if (reset_n) begin
            check("cyc_out_port", {16'h0, out_port}, {16'h0, m_data});
            check("cyc_hex_seg", {4'h0, hex_seg}, {4'h0, m_seg});
            check("cyc_readdata", readdata, model_read(address));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read_check(input string name, input logic [2:0] a,
                                  input logic [31:0] mask, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(name, readdata & mask, exp);
        chipselect = 1'b0;
    endtask

    task automatic wait_toggle_edge(input logic want_toggle);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_div != 0 && ((((m_t + 1) % m_div) == 0) == want_toggle)) found = 1;
            else tick();
        end
        if (!found) check("wait_toggle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        check("rst_out_port", {16'h0, out_port}, 32'h0);
        check("rst_hex_seg", {4'h0, hex_seg}, {4'h0, {4{7'h40}}});
        bus_read_check("rst_status", 3'd6, 32'hFFFF_FFFF, 32'h1);
        bus_read_check("rst_blink_div", 3'd3, 32'hFFFF_FFFF, 32'd25000000);
        tick();

        // DATA write: out_port immediately, segments one clock later
        bus_write(3'd0, 32'hFFFF_1A8F);
        check("data_out_port", {16'h0, out_port}, 32'h1A8F);
        tick();
        check("data_hex_seg", {4'h0, hex_seg}, {4'h0, 7'h79, 7'h08, 7'h00, 7'h0E});
        bus_read_check("data_readback", 3'd0, 32'hFFFF_FFFF, 32'h1A8F);

        // Atomic set / clear
        bus_write(3'd4, 32'h0030);
        bus_read_check("set_readback", 3'd0, 32'hFFFF_FFFF, 32'h1ABF);
        bus_write(3'd5, 32'h000F);
        bus_read_check("clr_readback", 3'd0, 32'hFFFF_FFFF, 32'h1AB0);
        bus_read_check("set_reads_zero", 3'd4, 32'hFFFF_FFFF, 32'h0);
        bus_read_check("clr_reads_zero", 3'd5, 32'hFFFF_FFFF, 32'h0);
        bus_read_check("rsvd_reads_zero", 3'd7, 32'hFFFF_FFFF, 32'h0);
        tick();

        // Blink digit 1 with a 4-cycle half-period
        bus_write(3'd2, 32'h2);
        bus_write(3'd3, 32'd4);
        repeat (5) tick();
        check("blink_dark", {25'h0, hex_seg[13:7]}, 32'h7F);
        check("blink_steady0", {25'h0, hex_seg[6:0]}, 32'h40);
        repeat (4) tick();
        check("blink_lit", {25'h0, hex_seg[13:7]}, 32'h03);
        check("blink_steady3", {25'h0, hex_seg[27:21]}, 32'h79);

        // Event flag: plain W1C clears, W1C on a toggle edge loses to the set
        wait_toggle_edge(1'b0);
        bus_write(3'd6, 32'h2);
        bus_read_check("w1c_clears", 3'd6, 32'h2, 32'h0);
        tick();
        wait_toggle_edge(1'b1);
        bus_write(3'd6, 32'h2);
        bus_read_check("w1c_set_wins", 3'd6, 32'h2, 32'h2);
        tick();

        // Blank all digits, out_port untouched
        bus_write(3'd1, 32'hF);
        tick();
        check("blank_hex_seg", {4'h0, hex_seg}, {4'h0, {4{7'h7F}}});
        check("blank_out_port", {16'h0, out_port}, 32'h1AB0);
        bus_write(3'd1, 32'h0);

        // Zero divider freezes the blink visible
        bus_write(3'd3, 32'd0);
        repeat (6) tick();
        bus_read_check("div0_phase", 3'd6, 32'h1, 32'h1);
        tick();

        // Reset mid-blink at phase 0, cnt 2
        bus_write(3'd3, 32'd4);
        for (int i = 0; i < 20 && !(model_phase() == 1'b0 && (m_t % 4) == 2); i++) tick();
        check("mid_blink_reached", {31'h0, model_phase()}, 32'h0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_port", {16'h0, out_port}, 32'h0);
        check("mid_rst_hex_seg", {4'h0, hex_seg}, {4'h0, {4{7'h40}}});
        bus_read_check("mid_rst_status", 3'd6, 32'hFFFF_FFFF, 32'h1);
        bus_read_check("mid_rst_div", 3'd3, 32'hFFFF_FFFF, 32'd25000000);
        bus_read_check("mid_rst_blink", 3'd2, 32'hFFFF_FFFF, 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
